pixel_cache_arbiter: RTL and testbench
======================================

Name: pixel_cache_arbiter

Overview:
- Shares the single pixel_cache read port between N_REQ pixel requesters, for example the edge_search engines inside a bounding-box finder and the display readout path.
- Each requester sees the same x/y/request/pixel/ready interface it would see connected directly to the cache.
- The arbiter grants one transaction at a time, round-robin, and keeps the cache request and coordinates stable until the cache answers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- COORD_W, 10, width of each x and y coordinate.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_request  in  N_REQ  per-requester request level; bit i belongs to requester i.
- req_x  in  N_REQ*COORD_W  packed x coordinates; requester i uses bits [i*COORD_W +: COORD_W].
- req_y  in  N_REQ*COORD_W  packed y coordinates, same packing as req_x.
- req_pixel  out  N_REQ  pixel value routed to each requester; only meaningful with the matching req_ready bit.
- req_ready  out  N_REQ  one-cycle response strobe per requester.
- x  out  COORD_W  cache read x coordinate.
- y  out  COORD_W  cache read y coordinate.
- request  out  1  cache request level.
- pixel  in  1  cache pixel value; valid only when ready=1.
- ready  in  1  cache response strobe.
- grant_id  out  $clog2(N_REQ)  index of the requester currently or most recently granted.
- busy  out  1  a cache transaction is outstanding.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high; asserting it forces every register to its reset value immediately.
- Reset values: request=0, x=0, y=0, busy=0, grant_id=N_REQ-1, last_grant=N_REQ-1, req_ready=0, state=IDLE. Requester 0 therefore wins first after reset.
- IDLE state:
  - If any req_request bit is set, pick the winner by scanning cyclically from last_grant+1 and taking the first set bit.
  - Register the winner's req_x/req_y into x/y, set grant_id and last_grant to the winner, set request=1 and busy=1, and move to BUSY.
  - Latency: a request seen in cycle 0 gives request=1 at the cache in cycle 1.
- BUSY state:
  - request, x, y and grant_id are held constant until ready=1.
  - In the ready cycle, req_ready[grant_id] equals ready combinationally and req_pixel[grant_id] equals pixel. Every other req_ready bit stays 0.
  - On that clock edge, request, busy and the state return to 0, 0 and IDLE.
  - No new grant is made in the ready cycle, so there is one idle cycle between cache transactions.
  - req_pixel bits of non-granted requesters are 0.
- Requester rules:
  - A requester holds request high with stable coordinates until it sees its ready.
  - If its request is still high in the cycle after ready, that is a new request. It is arbitrated fairly, so other pending requesters go first.
- Abandoned request: if the granted requester drops req_request while BUSY, the cache transaction still completes and request stays high until ready. req_ready for that requester is suppressed, and the response is discarded.
- ready received while IDLE is ignored; no req_ready pulse is produced.
- Simultaneous requests are ordered strictly round-robin. A requester waits at most N_REQ-1 other transactions before it is granted.
- Reset in BUSY aborts the transaction: request drops immediately. Any late ready after reset is ignored.
- No combinational path from req_request or req_x/req_y to request, x or y; those outputs are registered.

Test Plan:
- Single request: after reset, requester 2 requests (5,7) alone; cache returns ready with pixel=1 three cycles later -> x=5, y=7, request=1 from cycle 1 until ready; req_ready=4'b0100 with req_pixel[2]=1 for exactly one cycle; grant_id=2.
- Round-robin: all four requesters hold request; cache answers every transaction with ready after 2 cycles -> grant order 0,1,2,3,0. Each transaction is 4 cycles (request issued, two wait cycles, ready), and no requester is granted twice before all have been served.
- Stability: granted requester 1 changes req_x from 10 to 20 mid-transaction -> x stays 10 until ready.
- Abandon: requester 3 is granted, then drops req_request before ready -> request stays 1 until ready; req_ready stays 0; the arbiter then serves the next pending requester.
- Reset mid-BUSY: assert reset during an outstanding request -> request=0, busy=0 immediately. A ready pulse arriving afterward produces no req_ready, and the next grant goes to requester 0.
- Spurious ready: ready=1 while IDLE with no requests -> all req_ready stay 0 and the state remains IDLE.

Source files
------------

// File: rtl/pixel_cache_arbiter.sv
// Round-robin arbiter sharing one pixel_cache read port among N_REQ requesters.
// One transaction outstanding at a time; cache-side outputs are fully registered.
module pixel_cache_arbiter #(
  parameter int N_REQ   = 4,
  parameter int COORD_W = 10,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_request,
  input  logic [N_REQ*COORD_W-1:0] req_x,
  input  logic [N_REQ*COORD_W-1:0] req_y,
  output logic [N_REQ-1:0]         req_pixel,
  output logic [N_REQ-1:0]         req_ready,
  output logic [COORD_W-1:0]       x,
  output logic [COORD_W-1:0]       y,
  output logic                     request,
  input  logic                     pixel,
  input  logic                     ready,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, nxt_state;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            abandoned;

  // grant_id doubles as the round-robin pointer (last granted requester).
  always_comb begin
    int idx;
    idx    = 0;
    winner = grant_id;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(grant_id) + k) % N_REQ;
      if (!found && req_request[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (found) nxt_state = BUSY;
      BUSY:    if (ready) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Grant capture: coordinates and winner are frozen for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      grant_id  <= ID_W'(N_REQ - 1);
      abandoned <= 1'b0;
    end else if (state == IDLE && found) begin
      x         <= req_x[int'(winner)*COORD_W +: COORD_W];
      y         <= req_y[int'(winner)*COORD_W +: COORD_W];
      grant_id  <= winner;
      abandoned <= 1'b0;
    end else if (state == BUSY && !ready && !req_request[grant_id]) begin
      abandoned <= 1'b1;
    end
  end

  assign request = (state == BUSY);
  assign busy    = (state == BUSY);

  // A requester that let go at any point during its transaction gets no strobe.
  always_comb begin
    req_ready = '0;
    req_pixel = '0;
    if (state == BUSY && ready && !abandoned && req_request[grant_id]) begin
      req_ready[grant_id] = 1'b1;
      req_pixel[grant_id] = pixel;
    end
  end

endmodule

// File: tb/tb_pixel_cache_arbiter.sv
// Directed bench for pixel_cache_arbiter: vector table plus multi-cycle sequences.
module tb_pixel_cache_arbiter;

  localparam int N = 4;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_request;
  logic [N*W-1:0] req_x, req_y;
  logic [N-1:0]   req_pixel, req_ready;
  logic [W-1:0]   x, y;
  logic           request, pixel, ready, busy;
  logic [1:0]     grant_id;

  int total = 0;
  int bad   = 0;

  pixel_cache_arbiter #(.N_REQ(N), .COORD_W(W)) dut (
    .clk(clk), .reset(reset), .req_request(req_request), .req_x(req_x), .req_y(req_y),
    .req_pixel(req_pixel), .req_ready(req_ready), .x(x), .y(y), .request(request),
    .pixel(pixel), .ready(ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]     req;
    logic [N*W-1:0] xs, ys;
    logic           rdy_in, pix_in;
    logic           exp_req;
    int             exp_x, exp_y, exp_gid;
    logic [3:0]     exp_rdy, exp_pix;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic [3:0] r, int x1, int x2, int y1, int y2,
                              logic rd, logic px, logic er, int ex, int ey, int eg,
                              logic [3:0] erd, logic [3:0] epx);
    vec_t v;
    v.req = r;
    v.xs = '0; v.xs[W +: W] = W'(x1); v.xs[2*W +: W] = W'(x2);
    v.ys = '0; v.ys[W +: W] = W'(y1); v.ys[2*W +: W] = W'(y2);
    v.rdy_in = rd; v.pix_in = px; v.exp_req = er;
    v.exp_x = ex; v.exp_y = ey; v.exp_gid = eg; v.exp_rdy = erd; v.exp_pix = epx;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_request = '0; req_x = '0; req_y = '0; ready = 1'b0; pixel = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int exp_id;
    reset = 1'b1;
    req_request = '0; req_x = '0; req_y = '0; ready = 1'b0; pixel = 1'b0;

    // Single request from 2, spurious ready, then stability of x for requester 1.
    tbl[0]  = mk(4'b0100,  0, 5, 0, 7, 0, 0, 0,  0, 0, 3, 4'b0000, 4'b0000);
    tbl[1]  = mk(4'b0100,  0, 5, 0, 7, 0, 0, 1,  5, 7, 2, 4'b0000, 4'b0000);
    tbl[2]  = mk(4'b0100,  0, 5, 0, 7, 0, 0, 1,  5, 7, 2, 4'b0000, 4'b0000);
    tbl[3]  = mk(4'b0100,  0, 5, 0, 7, 1, 1, 1,  5, 7, 2, 4'b0100, 4'b0100);
    tbl[4]  = mk(4'b0000,  0, 5, 0, 7, 0, 0, 0,  5, 7, 2, 4'b0000, 4'b0000);
    tbl[5]  = mk(4'b0000,  0, 5, 0, 7, 1, 1, 0,  5, 7, 2, 4'b0000, 4'b0000);
    tbl[6]  = mk(4'b0000,  0, 5, 0, 7, 0, 0, 0,  5, 7, 2, 4'b0000, 4'b0000);
    tbl[7]  = mk(4'b0010, 10, 0, 3, 0, 0, 0, 0,  5, 7, 2, 4'b0000, 4'b0000);
    tbl[8]  = mk(4'b0010, 20, 0, 3, 0, 0, 0, 1, 10, 3, 1, 4'b0000, 4'b0000);
    tbl[9]  = mk(4'b0010, 20, 0, 3, 0, 0, 0, 1, 10, 3, 1, 4'b0000, 4'b0000);
    tbl[10] = mk(4'b0010, 20, 0, 3, 0, 1, 0, 1, 10, 3, 1, 4'b0010, 4'b0000);
    tbl[11] = mk(4'b0000, 20, 0, 3, 0, 0, 0, 0, 10, 3, 1, 4'b0000, 4'b0000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_request", int'(request), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_gid", int'(grant_id), 3);
    chk("rst_ready", int'(req_ready), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      req_request = tbl[i].req; req_x = tbl[i].xs; req_y = tbl[i].ys;
      ready = tbl[i].rdy_in; pixel = tbl[i].pix_in;
      #1;
      chk($sformatf("v%0d_request", i), int'(request), int'(tbl[i].exp_req));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].exp_req));
      chk($sformatf("v%0d_x", i), int'(x), tbl[i].exp_x);
      chk($sformatf("v%0d_y", i), int'(y), tbl[i].exp_y);
      chk($sformatf("v%0d_gid", i), int'(grant_id), tbl[i].exp_gid);
      chk($sformatf("v%0d_req_ready", i), int'(req_ready), int'(tbl[i].exp_rdy));
      chk($sformatf("v%0d_req_pixel", i), int'(req_pixel), int'(tbl[i].exp_pix));
      step();
    end

    // Round-robin with all four requesting; cache answers after two wait cycles.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = W'(100 + i);
      req_y[i*W +: W] = W'(200 + i);
    end
    req_request = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_id = t % N;
      n = 0;
      while (!request && n < 10) begin
        step();
        n++;
      end
      chk($sformatf("rr%0d_gap", t), n, 1);
      chk($sformatf("rr%0d_gid", t), int'(grant_id), exp_id);
      chk($sformatf("rr%0d_x", t), int'(x), 100 + exp_id);
      chk($sformatf("rr%0d_y", t), int'(y), 200 + exp_id);
      step();
      chk($sformatf("rr%0d_wait1", t), int'(request), 1);
      step();
      chk($sformatf("rr%0d_wait2", t), int'(request), 1);
      step();
      ready = 1'b1; pixel = exp_id[0];
      #1;
      chk($sformatf("rr%0d_req_ready", t), int'(req_ready), 1 << exp_id);
      chk($sformatf("rr%0d_req_pixel", t), int'(req_pixel), exp_id[0] << exp_id);
      step();
      ready = 1'b0; pixel = 1'b0;
      chk($sformatf("rr%0d_idle", t), int'(request), 0);
    end

    // Requester 3 abandons its transaction while 0 is waiting.
    do_reset();
    req_x[3*W +: W] = W'(33);
    req_request = 4'b1000;
    step();
    chk("ab_request", int'(request), 1);
    chk("ab_gid", int'(grant_id), 3);
    chk("ab_x", int'(x), 33);
    req_request = 4'b0001;
    step();
    chk("ab_hold", int'(request), 1);
    ready = 1'b1; pixel = 1'b1;
    #1;
    chk("ab_req_ready", int'(req_ready), 0);
    chk("ab_req_pixel", int'(req_pixel), 0);
    chk("ab_ready_cycle_request", int'(request), 1);
    step();
    ready = 1'b0; pixel = 1'b0;
    chk("ab_idle", int'(request), 0);
    step();
    chk("ab_next_request", int'(request), 1);
    chk("ab_next_gid", int'(grant_id), 0);

    // Reset during an outstanding transaction, then a late ready.
    do_reset();
    req_request = 4'b0100;
    req_x[2*W +: W] = W'(9);
    step();
    chk("rb_busy_before", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rb_request_async", int'(request), 0);
    chk("rb_busy_async", int'(busy), 0);
    chk("rb_gid_async", int'(grant_id), 3);
    step();
    reset = 1'b0;
    req_request = 4'b0000;
    ready = 1'b1; pixel = 1'b1;
    #1;
    chk("rb_late_req_ready", int'(req_ready), 0);
    step();
    chk("rb_late_busy", int'(busy), 0);
    ready = 1'b0; pixel = 1'b0;
    req_request = 4'b0101;
    step();
    chk("rb_next_request", int'(request), 1);
    chk("rb_next_gid", int'(grant_id), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
